// File: rtl/execute_stage.sv
// execute_stage: forwarding, ALU, branch/jump resolution and EX/MEM register.
// Inputs: ID/EX control, operands, PC, immediate, forward selects, writeback result, EX/MEM clear.
// Outputs: o_zero_e/o_pcsrc_e/o_pctarget_e to fetch (combinational); *_m EX/MEM register to memory stage.
module execute_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_regwrite_e,
  input  logic [1:0]            i_resultsrc_e,
  input  logic                  i_memwrite_e,
  input  logic                  i_jump_e,
  input  logic                  i_branch_e,
  input  logic [2:0]            i_aluctrl_e,
  input  logic                  i_alusrc_e,
  input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
  input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
  input  logic [DATA_WIDTH-1:0] i_pc_e,
  input  logic [DATA_WIDTH-1:0] i_pc4_e,
  input  logic [DATA_WIDTH-1:0] i_immext_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic [1:0]            i_forward_a_e,
  input  logic [1:0]            i_forward_b_e,
  input  logic [DATA_WIDTH-1:0] i_result_w,
  input  logic                  i_clr_m,
  output logic                  o_zero_e,
  output logic                  o_pcsrc_e,
  output logic [DATA_WIDTH-1:0] o_pctarget_e,
  output logic                  o_regwrite_m,
  output logic [1:0]            o_resultsrc_m,
  output logic                  o_memwrite_m,
  output logic [DATA_WIDTH-1:0] o_aluresult_m,
  output logic [DATA_WIDTH-1:0] o_writedata_m,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_m,
  output logic [DATA_WIDTH-1:0] o_pc4_m
);
  logic [DATA_WIDTH-1:0] src_a, src_b, write_data, alu_result;
  // Forward select 10 feeds back the registered EX/MEM result, so there is no combinational loop.
  always_comb begin
    src_a = i_forward_a_e == 2'b01 ? i_result_w : i_forward_a_e == 2'b10 ? o_aluresult_m : i_rs1_data_e;
    write_data = i_forward_b_e == 2'b01 ? i_result_w : i_forward_b_e == 2'b10 ? o_aluresult_m : i_rs2_data_e;
    src_b = i_alusrc_e ? i_immext_e : write_data;
    case (i_aluctrl_e)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end
  assign o_zero_e     = alu_result == '0;
  assign o_pcsrc_e    = (i_branch_e & o_zero_e) | i_jump_e;
  assign o_pctarget_e = i_pc_e + i_immext_e;
  // Clear squashes only the side-effecting controls; data fields are harmless once those are zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_regwrite_m  <= 1'b0;
      o_resultsrc_m <= 2'b00;
      o_memwrite_m  <= 1'b0;
      o_aluresult_m <= '0;
      o_writedata_m <= '0;
      o_rd_addr_m   <= '0;
      o_pc4_m       <= '0;
    end else begin
      o_regwrite_m  <= i_clr_m ? 1'b0 : i_regwrite_e;
      o_resultsrc_m <= i_clr_m ? 2'b00 : i_resultsrc_e;
      o_memwrite_m  <= i_clr_m ? 1'b0 : i_memwrite_e;
      o_aluresult_m <= alu_result;
      o_writedata_m <= write_data;
      o_rd_addr_m   <= i_rd_addr_e;
      o_pc4_m       <= i_pc4_e;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table-driven and scoreboard checks of execute_stage.
module tb_execute_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic regwrite, memwrite, jump, branch, alusrc, clr;
  logic [1:0] resultsrc, fa, fb;
  logic [2:0] ctrl;
  logic [31:0] rs1, rs2, pc, pc4, imm, rw;
  logic [4:0] rd;
  logic zero, pcsrc, regwrite_m, memwrite_m;
  logic [1:0] resultsrc_m;
  logic [31:0] target, alu_m, wd_m, pc4_m;
  logic [4:0] rd_m;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic rw; logic [1:0] rs; logic mw;
    logic [31:0] alu, wd; logic [4:0] rd; logic [31:0] pc4;
  } exp_t;
  exp_t q[$];
  logic [31:0] exp_alu_m = '0;
  typedef struct { logic [2:0] ctrl; logic [31:0] rs1, imm, exp; } vec_t;
  vec_t tbl[12];

  execute_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_regwrite_e(regwrite), .i_resultsrc_e(resultsrc),
    .i_memwrite_e(memwrite), .i_jump_e(jump), .i_branch_e(branch), .i_aluctrl_e(ctrl),
    .i_alusrc_e(alusrc), .i_rs1_data_e(rs1), .i_rs2_data_e(rs2), .i_pc_e(pc), .i_pc4_e(pc4),
    .i_immext_e(imm), .i_rd_addr_e(rd), .i_forward_a_e(fa), .i_forward_b_e(fb),
    .i_result_w(rw), .i_clr_m(clr), .o_zero_e(zero), .o_pcsrc_e(pcsrc), .o_pctarget_e(target),
    .o_regwrite_m(regwrite_m), .o_resultsrc_m(resultsrc_m), .o_memwrite_m(memwrite_m),
    .o_aluresult_m(alu_m), .o_writedata_m(wd_m), .o_rd_addr_m(rd_m), .o_pc4_m(pc4_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] reg_v);
    return s == 2'b01 ? rw : s == 2'b10 ? exp_alu_m : reg_v;
  endfunction

  function automatic logic [31:0] model_alu();
    logic [31:0] a, b;
    a = fwd(fa, rs1);
    b = alusrc ? imm : fwd(fb, rs2);
    case (ctrl)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  // Check combinational outputs, push the expected EX/MEM contents, clock once, pop and compare.
  task automatic step();
    exp_t e;
    logic [31:0] r;
    r = model_alu();
    check("zero_e", zero, r == 0);
    check("pcsrc_e", pcsrc, (branch & (r == 0)) | jump);
    check("pctarget_e", target, pc + imm);
    e = '{clr ? 1'b0 : regwrite, clr ? 2'b00 : resultsrc, clr ? 1'b0 : memwrite, r, fwd(fb, rs2), rd, pc4};
    q.push_back(e);
    exp_alu_m = r;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = q.pop_front();
      check("regwrite_m", regwrite_m, e.rw);
      check("resultsrc_m", resultsrc_m, e.rs);
      check("memwrite_m", memwrite_m, e.mw);
      check("aluresult_m", alu_m, e.alu);
      check("writedata_m", wd_m, e.wd);
      check("rd_addr_m", rd_m, e.rd);
      check("pc4_m", pc4_m, e.pc4);
    end
  endtask

  task automatic idle();
    {regwrite, memwrite, jump, branch, alusrc, clr} = '0;
    {resultsrc, fa, fb, ctrl, rd} = '0;
    {rs1, rs2, pc, pc4, imm, rw} = '0;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, " regwrite_m"}, regwrite_m, 0);
    check({tag, " resultsrc_m"}, resultsrc_m, 0);
    check({tag, " memwrite_m"}, memwrite_m, 0);
    check({tag, " aluresult_m"}, alu_m, 0);
    check({tag, " writedata_m"}, wd_m, 0);
    check({tag, " rd_addr_m"}, rd_m, 0);
    check({tag, " pc4_m"}, pc4_m, 0);
  endtask

  initial begin
    tbl[0]  = '{3'b001, 32'h80000000, 32'h1, 32'h7FFFFFFF};
    tbl[1]  = '{3'b101, 32'h80000000, 32'h1, 32'h1};
    tbl[2]  = '{3'b010, 32'h80000000, 32'h1, 32'h0};
    tbl[3]  = '{3'b011, 32'h80000000, 32'h1, 32'h80000001};
    tbl[4]  = '{3'b110, 32'h80000000, 32'h1, 32'h0};
    tbl[5]  = '{3'b000, 32'h80000000, 32'h1, 32'h80000001};
    tbl[6]  = '{3'b100, 32'h80000000, 32'h1, 32'h0};
    tbl[7]  = '{3'b111, 32'h80000000, 32'h1, 32'h0};
    tbl[8]  = '{3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h0};
    tbl[9]  = '{3'b101, 32'hFFFFFFFF, 32'h0, 32'h1};
    tbl[10] = '{3'b001, 32'h0, 32'h1, 32'hFFFFFFFF};
    tbl[11] = '{3'b000, 32'hFFFFFFFF, 32'h1, 32'h0};
    // Reset held with busy inputs
    idle();
    {regwrite, memwrite} = 2'b11;
    resultsrc = 2'b10; rs1 = 32'h5; rs2 = 32'h7; rd = 5'd9; pc4 = 32'h44;
    repeat (3) @(posedge clk);
    #1;
    check_m_zero("reset");
    idle();
    #1;
    check("reset zero_e", zero, 1);
    check("reset pcsrc_e", pcsrc, 0);
    check("reset pctarget_e", target, 0);
    rst_n = 1'b1;
    // First instruction after reset
    regwrite = 1'b1; rs1 = 32'd5; rs2 = 32'd7; rd = 5'd3; pc4 = 32'h8;
    #1;
    step();
    check("first add aluresult_m", alu_m, 32'd12);
    check("first add writedata_m", wd_m, 32'd7);
    // ALU sweep
    for (int i = 0; i < 12; i++) begin
      idle();
      alusrc = 1'b1; ctrl = tbl[i].ctrl; rs1 = tbl[i].rs1; imm = tbl[i].imm; rs2 = 32'h55;
      #1;
      step();
      check($sformatf("alu vec%0d", i), alu_m, tbl[i].exp);
    end
    // Forwarding
    idle(); alusrc = 1'b1; rs1 = 32'd4; #1; step();
    check("fwd setup", alu_m, 32'd4);
    rs1 = 32'd1; rw = 32'd9; fa = 2'b01; #1; step();
    check("fwdA=01", alu_m, 32'd9);
    fa = 2'b10; rw = 32'd0; #1; step();
    check("fwdA=10", alu_m, 32'd9);
    imm = 32'd1; #1; step();
    check("fwdA=10 chain1", alu_m, 32'd10);
    #1; step();
    check("fwdA=10 chain2", alu_m, 32'd11);
    fa = 2'b00; imm = 32'd0; fb = 2'b10; memwrite = 1'b1; #1; step();
    check("fwdB=10 writedata_m", wd_m, 32'd11);
    check("fwdB=10 aluresult_m", alu_m, 32'd1);
    idle(); alusrc = 1'b1; rs1 = 32'd3; rw = 32'd9; fa = 2'b11; fb = 2'b11; rs2 = 32'd6; #1; step();
    check("fwd=11 aluresult_m", alu_m, 32'd3);
    check("fwd=11 writedata_m", wd_m, 32'd6);
    // Branch
    idle(); branch = 1'b1; ctrl = 3'b001; rs1 = 32'h1234; rs2 = 32'h1234; pc = 32'h100; imm = 32'hFFFFFFF0; #1;
    check("beq zero_e", zero, 1);
    check("beq pcsrc_e", pcsrc, 1);
    check("beq pctarget_e", target, 32'hF0);
    step();
    rs2 = 32'h1235; #1;
    check("bne pcsrc_e", pcsrc, 0);
    step();
    // Jump
    idle(); jump = 1'b1; rs1 = 32'd1; rs2 = 32'd2; resultsrc = 2'b10; pc4 = 32'h204; regwrite = 1'b1; #1;
    check("jal pcsrc_e", pcsrc, 1);
    check("jal zero_e", zero, 0);
    step();
    check("jal pc4_m", pc4_m, 32'h204);
    check("jal resultsrc_m", resultsrc_m, 2'b10);
    // Clear
    idle(); regwrite = 1'b1; memwrite = 1'b1; resultsrc = 2'b01; clr = 1'b1; rs1 = 32'h77; rs2 = 32'h3; rd = 5'd7; #1;
    step();
    check("clr regwrite_m", regwrite_m, 0);
    check("clr memwrite_m", memwrite_m, 0);
    check("clr resultsrc_m", resultsrc_m, 0);
    check("clr aluresult_m", alu_m, 32'h7A);
    clr = 1'b0; #1; step();
    check("post-clr regwrite_m", regwrite_m, 1);
    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_m_zero("async");
    q.delete();
    exp_alu_m = '0;
    #1;
    rst_n = 1'b1;
    idle(); #1; step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
